// File: rtl/nx_indirect_mem_arbiter.sv
// nx_indirect_mem_arbiter
//   Shares one single-port RAM between the software indirect-access path and
//   the functional hardware port. At most one access is issued per cycle, and
//   every read or compare carries a tag down a RD_LATENCY-deep pipeline. That
//   tag routes the returning RAM word back to the port that asked for it.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   sw_cs/sw_ce/sw_we                software request valid / compare / write
//   sw_add, sw_wdat                  software address, write or compare data
//   yield, reset                     controller starving / init sweep active
//   grant, rsp                       software accepted / response pulse
//   sw_rdat, sw_match, sw_aindex     software read data, compare result, index
//   hw_rd, hw_wr, hw_add, hw_wdat    hardware request
//   hw_gnt, hw_rvld, hw_rdat         hardware accepted / read-data valid, data
//   mem_cs/mem_we/mem_add/mem_wdat   RAM access
//   mem_rdat                         RAM read data, RD_LATENCY after access
module nx_indirect_mem_arbiter #(
  parameter int N_DATA_BITS   = 38,
  parameter int N_ENTRIES     = 16384,
  parameter int N_ADDR_BITS   = 14,
  parameter int N_AINDEX_BITS = 13,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sw_cs,
  input  logic                     sw_ce,
  input  logic                     sw_we,
  input  logic [N_ADDR_BITS-1:0]   sw_add,
  input  logic [N_DATA_BITS-1:0]   sw_wdat,
  input  logic                     yield,
  input  logic                     reset,
  output logic                     grant,
  output logic                     rsp,
  output logic [N_DATA_BITS-1:0]   sw_rdat,
  output logic                     sw_match,
  output logic [N_AINDEX_BITS-1:0] sw_aindex,
  input  logic                     hw_rd,
  input  logic                     hw_wr,
  input  logic [N_ADDR_BITS-1:0]   hw_add,
  input  logic [N_DATA_BITS-1:0]   hw_wdat,
  output logic                     hw_gnt,
  output logic                     hw_rvld,
  output logic [N_DATA_BITS-1:0]   hw_rdat,
  output logic                     mem_cs,
  output logic                     mem_we,
  output logic [N_ADDR_BITS-1:0]   mem_add,
  output logic [N_DATA_BITS-1:0]   mem_wdat,
  input  logic [N_DATA_BITS-1:0]   mem_rdat
);

  localparam int LAST = RD_LATENCY - 1;

  logic hw_req;
  logic sw_wins;
  logic hw_wins;
  logic issue_rd;

  assign hw_req = hw_rd | hw_wr;

  // Priority: the init sweep locks hardware out entirely, a starving
  // controller pre-empts hardware, otherwise hardware goes first.
  always_comb begin
    sw_wins = 1'b0;
    hw_wins = 1'b0;
    if (reset) begin
      sw_wins = 1'b1;
    end else if (yield && sw_cs) begin
      sw_wins = 1'b1;
    end else if (hw_req) begin
      hw_wins = 1'b1;
    end else begin
      sw_wins = 1'b1;
    end
  end

  assign grant  = sw_cs & sw_wins;
  assign hw_gnt = hw_req & hw_wins;
  assign mem_cs = grant | hw_gnt;

  // A write flag wins over read/compare flags on either port.
  assign mem_we   = grant ? sw_we : (hw_gnt & hw_wr);
  assign mem_add  = grant ? sw_add : hw_add;
  assign mem_wdat = grant ? sw_wdat : hw_wdat;

  assign issue_rd = mem_cs & ~mem_we;

  // Tag pipeline. Only the index bits of the address are ever returned,
  // so only those are carried.
  logic                     tag_vld  [RD_LATENCY];
  logic                     tag_sw   [RD_LATENCY];
  logic                     tag_cmp  [RD_LATENCY];
  logic [N_AINDEX_BITS-1:0] tag_addr [RD_LATENCY];
  logic [N_DATA_BITS-1:0]   tag_data [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_vld[i]  <= 1'b0;
        tag_sw[i]   <= 1'b0;
        tag_cmp[i]  <= 1'b0;
        tag_addr[i] <= '0;
        tag_data[i] <= '0;
      end
    end else begin
      tag_vld[0]  <= issue_rd;
      tag_sw[0]   <= grant;
      tag_cmp[0]  <= grant & sw_ce;
      tag_addr[0] <= mem_add[N_AINDEX_BITS-1:0];
      tag_data[0] <= sw_wdat;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_sw[i]   <= tag_sw[i-1];
        tag_cmp[i]  <= tag_cmp[i-1];
        tag_addr[i] <= tag_addr[i-1];
        tag_data[i] <= tag_data[i-1];
      end
    end
  end

  // The last tag stage lines up with mem_rdat; capture it for its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp       <= 1'b0;
      sw_rdat   <= '0;
      sw_match  <= 1'b0;
      sw_aindex <= '0;
      hw_rvld   <= 1'b0;
      hw_rdat   <= '0;
    end else begin
      rsp     <= 1'b0;
      hw_rvld <= 1'b0;
      if (tag_vld[LAST]) begin
        if (tag_sw[LAST]) begin
          rsp <= 1'b1;
          if (tag_cmp[LAST]) begin
            sw_match  <= (mem_rdat == tag_data[LAST]);
            sw_aindex <= tag_addr[LAST];
          end else begin
            sw_rdat <= mem_rdat;
          end
        end else begin
          hw_rvld <= 1'b1;
          hw_rdat <= mem_rdat;
        end
      end
    end
  end

endmodule
